lsu_ctrl: RTL
=============

Name: lsu_ctrl

Overview:
- Load/store sequencer between the Address_Builder effective-address output and the data memory port.
- Accepts one load/store per start pulse and drives a single-outstanding req/ack memory handshake.
- Generates byte enables and lane-replicated write data; extracts and sign/zero-extends load data.
- Reports completion or error to the core stall logic.

Parameters:
- TIMEOUT, 16: max cycles in REQ waiting for mem_ack before a timeout error; 0 disables the timeout.
- TW, 5: width of the timeout counter; must satisfy 2^TW > TIMEOUT.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  launch request; sampled only in IDLE
- is_store  in  1  1 = store (S opcode), 0 = load (I_LOAD opcode)
- funct3  in  3  access size/sign per RV32I (LB 000, LH 001, LW 010, LBU 100, LHU 101; SB 000, SH 001, SW 010)
- addr  in  32  effective address (rs1 + imm)
- wdata  in  32  store data (rs2)
- busy  out  1  high whenever state != IDLE
- done  out  1  one-cycle completion pulse, for success or error
- err  out  1  qualifies done; high = access failed
- err_code  out  2  00 none, 01 misaligned, 10 illegal funct3, 11 timeout
- rdata  out  32  extended load result; held until the next successful load
- mem_req  out  1  memory request
- mem_we  out  1  memory write enable
- mem_addr  out  32  word-aligned address {addr[31:2], 2'b00}
- mem_be  out  4  byte enables
- mem_wdata  out  32  lane-replicated store data
- mem_ack  in  1  memory accept/response, one cycle
- mem_rdata  in  32  read word, valid with mem_ack

Behaviour:
- Reset: state = IDLE; every output and all internal registers = 0; timeout counter = 0.
- Reset asserted mid-operation aborts the access: mem_req drops asynchronously; no done is produced.
- States and transitions:
  - IDLE: on start, capture is_store, funct3, addr, wdata and run the checks.
    - Illegal funct3 (load 011/110/111; store anything other than 000/001/010) -> ERR, code 10.
    - Otherwise misaligned (word with addr[1:0] != 0, or half with addr[0] != 0) -> ERR, code 01.
    - Otherwise -> REQ.
    - Illegal funct3 takes priority over misalignment.
    - start while busy is ignored; no queueing.
  - REQ: mem_req = 1.
    - mem_we, mem_addr, mem_be and mem_wdata come from the captured values and stay stable until mem_ack.
    - mem_ack = 1 -> capture the extended load data (loads only) -> DONE.
    - Counter increments each REQ cycle without ack. When it reaches TIMEOUT (TIMEOUT != 0) -> ERR, code 11, and mem_req drops.
    - mem_ack in the same cycle as the timeout condition: the ack wins.
  - DONE: done = 1, err = 0, err_code = 00 -> IDLE.
  - ERR: done = 1, err = 1, err_code valid for this cycle only -> IDLE. rdata is unchanged.
- Latency: start at cycle N; REQ from N+1. With ack at N+1, done at N+2 (minimum 2 cycles). Each extra wait cycle adds 1. Error path: done at N+1.
- Byte enables:
  - byte: 0001 << addr[1:0]
  - half: 0011 << {addr[1], 0}
  - word: 1111
  - mem_be is 0 outside REQ.
- Write data: SB {4{wdata[7:0]}}, SH {2{wdata[15:0]}}, SW wdata. mem_wdata = 0 for loads.
- Load extraction: byte lane = mem_rdata[8*addr[1:0] +: 8]; half lane = mem_rdata[16*addr[1] +: 16].
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word through.
- mem_ack outside REQ is ignored.
- Stores never modify rdata.

Test Plan:
- LW, addr 0x100, mem_rdata 0xDEADBEEF, ack on the first REQ cycle -> mem_addr 0x100, mem_be 1111, done 2 cycles after start, rdata 0xDEADBEEF, err 0.
- LB, addr 0x103, mem_rdata 0x80112233; then LBU, same address and data -> LB gives mem_be 1000 and rdata 0xFFFFFF80; LBU gives rdata 0x00000080.
- SH, addr 0x202, wdata 0x1234ABCD, ack after 3 wait cycles -> mem_we 1, mem_addr 0x200, mem_be 1100, mem_wdata 0xABCDABCD held stable, done 5 cycles after start.
- LH at 0x101 -> no mem_req, done+err at start+1, err_code 01. Load with funct3 011 at 0x102 -> err_code 10.
- TIMEOUT=4, LW with mem_ack never asserted -> mem_req high exactly 4 cycles, then done+err with err_code 11, mem_req low.
- rst pulsed during REQ -> mem_req 0 immediately, busy 0, no done. A fresh start after reset completes normally; start pulsed while busy is ignored.

Source files
------------

// File: rtl/lsu_ctrl.sv
// Load/store sequencer: checks one access per start, then runs a single-outstanding req/ack memory handshake.
// Latency is 2 cycles minimum, plus one per mem_ack wait cycle (errors finish at start+1); start is ignored while busy.
module lsu_ctrl #(
  parameter int TIMEOUT = 16,
  parameter int TW      = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        is_store,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [1:0]  err_code,
  output logic [31:0] rdata,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, REQ, DONE, ERR} state_t;

  localparam logic [TW-1:0] TO_L  = TW'(TIMEOUT);
  localparam bit            TO_EN = (TIMEOUT != 0);

  state_t        state_q, state_d;
  logic          is_store_q;
  logic [2:0]    f3_q;
  logic [31:0]   addr_q, wdata_q, rdata_q;
  logic [1:0]    err_code_q;
  logic [TW-1:0] cnt_q;

  logic          f3_illegal, misalign, timeout_hit;
  logic [TW-1:0] cnt_inc;
  logic [31:0]   sh_b, sh_h, load_ext;

  always_comb begin
    if (is_store) f3_illegal = funct3[2] | (funct3[1:0] == 2'b11);
    else          f3_illegal = (funct3 == 3'b011) | (funct3[2:1] == 2'b11);
    misalign = ((funct3[1:0] == 2'b10) && (addr[1:0] != 2'b00)) ||
               ((funct3[1:0] == 2'b01) && addr[0]);
  end

  assign cnt_inc     = cnt_q + TW'(1);
  assign timeout_hit = TO_EN && (cnt_inc == TO_L);

  // Shift the addressed lane down to bit 0 before extension.
  assign sh_b = mem_rdata >> {addr_q[1:0], 3'b000};
  assign sh_h = mem_rdata >> {addr_q[1], 4'b0000};

  always_comb begin
    case (f3_q)
      3'b000:  load_ext = {{24{sh_b[7]}}, sh_b[7:0]};
      3'b001:  load_ext = {{16{sh_h[15]}}, sh_h[15:0]};
      3'b100:  load_ext = {24'h0, sh_b[7:0]};
      3'b101:  load_ext = {16'h0, sh_h[15:0]};
      default: load_ext = mem_rdata;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (start) state_d = (f3_illegal || misalign) ? ERR : REQ;
      REQ: begin
        if (mem_ack)          state_d = DONE;
        else if (timeout_hit) state_d = ERR;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      is_store_q <= 1'b0;
      f3_q       <= 3'b000;
      addr_q     <= 32'h0;
      wdata_q    <= 32'h0;
      rdata_q    <= 32'h0;
      err_code_q <= 2'b00;
      cnt_q      <= '0;
    end else begin
      if (state_q == IDLE && start) begin
        is_store_q <= is_store;
        f3_q       <= funct3;
        addr_q     <= addr;
        wdata_q    <= wdata;
        cnt_q      <= '0;
        err_code_q <= f3_illegal ? 2'b10 : (misalign ? 2'b01 : 2'b00);
      end else if (state_q == REQ) begin
        if (mem_ack) begin
          if (!is_store_q) rdata_q <= load_ext;
        end else begin
          cnt_q <= cnt_inc;
          if (timeout_hit) err_code_q <= 2'b11;
        end
      end
    end
  end

  always_comb begin
    busy      = (state_q != IDLE);
    done      = (state_q == DONE) || (state_q == ERR);
    err       = (state_q == ERR);
    err_code  = (state_q == ERR) ? err_code_q : 2'b00;
    rdata     = rdata_q;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = 32'h0;
    mem_be    = 4'b0000;
    mem_wdata = 32'h0;
    if (state_q == REQ) begin
      mem_req  = 1'b1;
      mem_we   = is_store_q;
      mem_addr = {addr_q[31:2], 2'b00};
      case (f3_q[1:0])
        2'b00:   mem_be = 4'b0001 << addr_q[1:0];
        2'b01:   mem_be = addr_q[1] ? 4'b1100 : 4'b0011;
        default: mem_be = 4'b1111;
      endcase
      if (is_store_q) begin
        case (f3_q[1:0])
          2'b00:   mem_wdata = {4{wdata_q[7:0]}};
          2'b01:   mem_wdata = {2{wdata_q[15:0]}};
          default: mem_wdata = wdata_q;
        endcase
      end
    end
  end

endmodule
